ball_generator: RTL and testbench

BALL_GENERATOR -- requirements
Module: ball_generator

---
 rtl/ball_generator_pkg.sv | 14 +
 rtl/ball_generator_axis.sv | 47 ++++
 rtl/ball_generator.sv | 128 ++++++++++++
 tb/tb_ball_generator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ball_generator_pkg.sv
// Shared VGA timing constants and ball FSM encodings.
// Imported by every ball_generator source file.
package ball_generator_pkg;

  localparam logic [10:0] H_VISIBLE_AREA = 11'd640;
  localparam logic [10:0] V_VISIBLE_AREA = 11'd480;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    COMMIT = 2'b10
  } state_t;

endpackage

// File: rtl/ball_generator_axis.sv
// Per-axis bounce arithmetic for the ball.
// Purely combinational; 11-bit sums so the far edge never wraps.
module ball_axis
  import ball_generator_pkg::*;
#(
  parameter int BALL_SIZE = 16,
  parameter int STEP      = 2
) (
  input  logic [9:0]  pos,
  input  logic        dir,
  input  logic [10:0] limit,
  output logic [9:0]  next_pos,
  output logic        next_dir,
  output logic        hit
);

  localparam logic [10:0] SIZE = 11'(BALL_SIZE);
  localparam logic [10:0] STP  = 11'(STEP);
  localparam logic [9:0]  STP10 = 10'(STEP);

  logic [10:0] far_edge;

  assign far_edge = {1'b0, pos} + SIZE + STP;
  assign next_dir = dir ^ hit;

  // dir 0 moves toward the limit, dir 1 toward zero
  always_comb begin
    next_pos = pos;
    hit      = 1'b0;
    if (!dir) begin
      if (far_edge > limit) begin
        next_pos = 10'(limit - SIZE);
        hit      = 1'b1;
      end else begin
        next_pos = pos + STP10;
      end
    end else begin
      if (pos < STP10) begin
        next_pos = 10'd0;
        hit      = 1'b1;
      end else begin
        next_pos = pos - STP10;
      end
    end
  end

endmodule

// File: rtl/ball_generator.sv
// Bouncing ball: per-frame position update and 1-bit video.
// Update runs IDLE -> CALC (shadow) -> COMMIT (copy, bounce pulse).
module ball_generator
  import ball_generator_pkg::*;
#(
  parameter int BALL_SIZE = 16,
  parameter int STEP      = 2,
  parameter int X0        = 100,
  parameter int Y0        = 50
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_HPos,
  input  logic [9:0] i_VPos,
  input  logic       i_HBlank,
  input  logic       i_VReset,
  input  logic       i_Enable,
  output logic       o_Video,
  output logic [9:0] o_BallX,
  output logic [9:0] o_BallY,
  output logic       o_Bounce
);

  localparam logic [10:0] SIZE = 11'(BALL_SIZE);

  state_t state, state_nx;

  logic [9:0] x, y;
  logic       dir_x, dir_y;

  logic [9:0] sh_x, sh_y;
  logic       sh_dx, sh_dy, sh_bounce;

  logic [9:0] nx_x, nx_y;
  logic       nx_dx, nx_dy, hit_x, hit_y;

  logic in_h, in_v;

  ball_axis #(
    .BALL_SIZE(BALL_SIZE),
    .STEP     (STEP)
  ) u_axis_x (
    .pos     (x),
    .dir     (dir_x),
    .limit   (H_VISIBLE_AREA),
    .next_pos(nx_x),
    .next_dir(nx_dx),
    .hit     (hit_x)
  );

  ball_axis #(
    .BALL_SIZE(BALL_SIZE),
    .STEP     (STEP)
  ) u_axis_y (
    .pos     (y),
    .dir     (dir_y),
    .limit   (V_VISIBLE_AREA),
    .next_pos(nx_y),
    .next_dir(nx_dy),
    .hit     (hit_y)
  );

  // FSM state register
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nx;
  end

  // next state and bounce pulse; a frame pulse mid-update is ignored
  always_comb begin
    state_nx = state;
    o_Bounce = 1'b0;
    unique case (state)
      IDLE:    if (i_VReset && i_Enable) state_nx = CALC;
      CALC:    state_nx = COMMIT;
      COMMIT: begin
        state_nx = IDLE;
        o_Bounce = sh_bounce;
      end
      default: state_nx = IDLE;
    endcase
  end

  // CALC latches the candidate update into the shadow set
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_dx     <= 1'b0;
      sh_dy     <= 1'b0;
      sh_bounce <= 1'b0;
    end else if (state == CALC) begin
      sh_x      <= nx_x;
      sh_y      <= nx_y;
      sh_dx     <= nx_dx;
      sh_dy     <= nx_dy;
      sh_bounce <= hit_x | hit_y;
    end
  end

  // COMMIT copies the shadow set into the live position
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      x     <= 10'(X0);
      y     <= 10'(Y0);
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else if (state == COMMIT) begin
      x     <= sh_x;
      y     <= sh_y;
      dir_x <= sh_dx;
      dir_y <= sh_dy;
    end
  end

  assign in_h = (i_HPos >= x) && ({1'b0, i_HPos} < ({1'b0, x} + SIZE));
  assign in_v = (i_VPos >= y) && ({1'b0, i_VPos} < ({1'b0, y} + SIZE));

  // registered pixel drive, one cycle behind the beam position
  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_Video <= 1'b0;
    else         o_Video <= !i_HBlank && in_h && in_v;
  end

  assign o_BallX = x;
  assign o_BallY = y;

endmodule

// File: tb/tb_ball_generator.sv
// Self-checking bench for ball_generator.
// Scoreboard of expected positions and bounce counts per frame.
module tb_ball_generator;

  localparam int SZ = 16;
  localparam int ST = 2;
  localparam int HV = 640;
  localparam int VV = 480;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       hblank, vreset, en_m, en_c;

  logic       vid_m, vid_c, bnc_m, bnc_c;
  logic [9:0] bx_m, by_m, bx_c, by_c;

  int checks = 0;
  int errors = 0;
  int nb_m = 0;
  int nb_c = 0;

  typedef struct {
    string tag;
    int    x;
    int    y;
    int    nb;
  } exp_t;

  exp_t sb_q[$];

  int mx, my, cx, cy;
  bit mdx, mdy, cdx, cdy;

  always #5 clk = ~clk;

  ball_generator u_dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_HPos  (hpos),
    .i_VPos  (vpos),
    .i_HBlank(hblank),
    .i_VReset(vreset),
    .i_Enable(en_m),
    .o_Video (vid_m),
    .o_BallX (bx_m),
    .o_BallY (by_m),
    .o_Bounce(bnc_m)
  );

  ball_generator #(
    .X0(622),
    .Y0(462)
  ) u_crn (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_HPos  (hpos),
    .i_VPos  (vpos),
    .i_HBlank(hblank),
    .i_VReset(vreset),
    .i_Enable(en_c),
    .o_Video (vid_c),
    .o_BallX (bx_c),
    .o_BallY (by_c),
    .o_Bounce(bnc_c)
  );

  always @(negedge clk) begin
    if (bnc_m) nb_m <= nb_m + 1;
    if (bnc_c) nb_c <= nb_c + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ax(input int p, input bit d, input int lim,
                             output int np, output bit nd, output bit hit);
    hit = 1'b0;
    if (!d) begin
      if (p + SZ + ST > lim) begin
        np = lim - SZ;
        hit = 1'b1;
      end else np = p + ST;
    end else begin
      if (p < ST) begin
        np = 0;
        hit = 1'b1;
      end else np = p - ST;
    end
    nd = d ^ hit;
  endfunction

  function automatic int step2(inout int px, inout int py,
                               inout bit dx, inout bit dy);
    int nx, ny;
    bit ndx, ndy, hx, hy;
    ax(px, dx, HV, nx, ndx, hx);
    ax(py, dy, VV, ny, ndy, hy);
    px = nx; py = ny; dx = ndx; dy = ndy;
    return (hx || hy) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mx = 100; my = 50; mdx = 0; mdy = 0;
    cx = 622; cy = 462; cdx = 0; cdy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input bit em, input bit ec, input bit late);
    exp_t e;
    int b0m, b0c, bm;
    b0m = nb_m; b0c = nb_c;
    en_m = em; en_c = ec;
    vreset = 1'b1;
    bm = em ? step2(mx, my, mdx, mdy) : 0;
    e.tag = "main"; e.x = mx; e.y = my; e.nb = bm;
    sb_q.push_back(e);
    bm = ec ? step2(cx, cy, cdx, cdy) : 0;
    e.tag = "crn"; e.x = cx; e.y = cy; e.nb = bm;
    sb_q.push_back(e);
    @(posedge clk);
    #1 if (!late) vreset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 vreset = 1'b0;
    e = sb_q.pop_front();
    check({e.tag, "_x"}, int'(bx_m), e.x);
    check({e.tag, "_y"}, int'(by_m), e.y);
    check({e.tag, "_bnc"}, nb_m - b0m, e.nb);
    e = sb_q.pop_front();
    check({e.tag, "_x"}, int'(bx_c), e.x);
    check({e.tag, "_y"}, int'(by_c), e.y);
    check({e.tag, "_bnc"}, nb_c - b0c, e.nb);
  endtask

  task automatic pix(input int h, input int v, input bit hb, input int exp,
                     input string tag);
    hpos = 10'(h); vpos = 10'(v); hblank = hb;
    @(posedge clk);
    #1 check(tag, int'(vid_m), exp);
  endtask

  initial begin
    int b0;
    rst = 1'b1; hpos = '0; vpos = '0; hblank = 1'b1;
    vreset = 1'b0; en_m = 1'b0; en_c = 1'b0;
    do_reset();

    check("rst_x", int'(bx_m), 100);
    check("rst_y", int'(by_m), 50);
    check("rst_vid", int'(vid_m), 0);
    check("rst_bnc", int'(bnc_m), 0);
    check("rst_cx", int'(bx_c), 622);
    check("rst_cy", int'(by_c), 462);

    frame(1, 1, 0);
    frame(1, 1, 0);
    frame(1, 1, 1);
    frame(1, 1, 0);

    for (int i = 0; i < 300; i++) frame(1, 0, i[0]);

    do_reset();
    check("rst2_x", int'(bx_m), 100);
    check("rst2_y", int'(by_m), 50);

    pix(100, 50, 0, 1, "vid_tl");
    pix(116, 50, 0, 0, "vid_right");
    pix(115, 65, 0, 1, "vid_br");
    pix(100, 50, 1, 0, "vid_hblank");
    pix(99, 50, 0, 0, "vid_left");
    pix(100, 66, 0, 0, "vid_below");
    pix(100, 49, 0, 0, "vid_above");
    hblank = 1'b1;

    frame(1, 0, 0);
    for (int i = 0; i < 3; i++) frame(0, 0, 0);

    b0 = nb_m;
    en_m = 1'b1; vreset = 1'b1;
    @(posedge clk);
    #1 vreset = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("midrst_x", int'(bx_m), 100);
    check("midrst_y", int'(by_m), 50);
    check("midrst_bnc", nb_m - b0, 0);

    frame(1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
